// File: rtl/mips16_fetch.sv
// MIPS16 instruction fetch: PC, one-outstanding imem req/ack, head-of-FIFO decode.
// Define MIPS16_FETCH_STATS_EN to add the saturating flush_count output.
module mips16_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [15:0] pcbranch,
    input  logic [15:0] pcjump,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic [15:0] pcplus2,
    output logic [2:0]  op,
    output logic        select,
    output logic [3:0]  funct
`ifdef MIPS16_FETCH_STATS_EN
    ,
    output logic [15:0] flush_count
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   stale_q, stale_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [15:0] fifo_instr_q [DEPTH];
    logic [15:0] fifo_pc_q    [DEPTH];

    logic          redirect;
    logic [15:0]   target;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_pop;
    logic [CW-1:0] count_push;
    logic [15:0]   head_instr;
    logic [15:0]   head_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        redirect   = jump | pcsrc;
        target     = jump ? pcjump : pcbranch;
        pop        = instr_valid & instr_ready;
        count_pop  = count_q - CW'(pop);
        count_push = count_pop + CW'(1);
        push       = 1'b0;
        state_d    = state_q;
        pc_d       = pc_q;
        stale_d    = stale_q;
        count_d    = count_pop;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect) begin
            // Flush wins over any same-cycle pop or returning data
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = target;
            state_d  = S_REQ;
            if (state_q == S_REQ && !imem_ack) begin
                state_d = S_DROP;
                stale_d = pc_q;
            end else if (state_q == S_DROP && !imem_ack) begin
                state_d = S_DROP;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (count_pop < FULL)
                        state_d = S_REQ;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        push    = 1'b1;
                        pc_d    = pc_q + 16'd2;
                        count_d = count_push;
                        state_d = (count_push < FULL) ? S_REQ : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (imem_ack)
                        state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
            if (pop)
                rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push)
                wr_ptr_d = ptr_inc(wr_ptr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            stale_q  <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            stale_q  <= stale_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload needs no reset: outputs are gated by instr_valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

    always_comb begin
        imem_req    = (state_q != S_IDLE);
        imem_addr   = (state_q == S_DROP) ? stale_q : pc_q;
        instr_valid = (count_q != '0);
        head_instr  = fifo_instr_q[rd_ptr_q];
        head_pc     = fifo_pc_q[rd_ptr_q];
        instr       = instr_valid ? head_instr : 16'h0000;
        instr_pc    = instr_valid ? head_pc : 16'h0000;
        pcplus2     = instr_valid ? head_pc + 16'd2 : 16'h0000;
        op          = instr[15:13];
        select      = instr[12];
        funct       = instr[3:0];
    end

`ifdef MIPS16_FETCH_STATS_EN
    logic [15:0] flush_q, flush_d;

    always_comb begin
        flush_d = flush_q;
        if (redirect && flush_q != 16'hFFFF)
            flush_d = flush_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flush_q <= 16'h0000;
        else
            flush_q <= flush_d;
    end

    assign flush_count = flush_q;
`endif

endmodule

// File: tb/tb_mips16_fetch.sv
// Randomized bench for mips16_fetch against a queue-based reference model.
module tb_mips16_fetch;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        pcsrc;
    logic        jump;
    logic [15:0] pcbranch;
    logic [15:0] pcjump;
    logic        instr_ready;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] pcplus2;
    logic [2:0]  op;
    logic        select;
    logic [3:0]  funct;

    logic        w_req;
    logic [15:0] w_addr;
    logic        w_valid;
    logic [15:0] w_instr;
    logic [15:0] w_pc;
    logic [15:0] w_p2;
    logic [2:0]  w_op;
    logic        w_sel;
    logic [3:0]  w_funct;

`ifdef MIPS16_FETCH_STATS_EN
    logic [15:0] flush_count;
    logic [15:0] w_flush;
`endif

    mips16_fetch #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pcsrc(pcsrc), .jump(jump),
        .pcbranch(pcbranch), .pcjump(pcjump),
        .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .pcplus2(pcplus2),
        .op(op), .select(select), .funct(funct)
`ifdef MIPS16_FETCH_STATS_EN
        , .flush_count(flush_count)
`endif
    );

    mips16_fetch #(.RESET_PC(16'hFFFE), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pcsrc(pcsrc), .jump(jump),
        .pcbranch(pcbranch), .pcjump(pcjump),
        .instr_ready(instr_ready), .instr_valid(w_valid),
        .instr(w_instr), .instr_pc(w_pc), .pcplus2(w_p2),
        .op(w_op), .select(w_sel), .funct(w_funct)
`ifdef MIPS16_FETCH_STATS_EN
        , .flush_count(w_flush)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mq [$];
    bit          m_req;
    bit          m_drop;
    logic [15:0] m_pc;
    logic [15:0] m_stale;
    logic [15:0] m_flush;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_req   = 1'b0;
        m_drop  = 1'b0;
        m_pc    = 16'h0000;
        m_stale = 16'h0000;
        m_flush = 16'h0000;
    endtask

    task automatic check_outputs();
        logic [31:0] head;
        logic [15:0] e_addr;
        logic        e_valid;
        e_valid = (mq.size() != 0);
        head    = e_valid ? mq[0] : 32'h0;
        e_addr  = m_drop ? m_stale : m_pc;
        check("req", {15'b0, imem_req}, {15'b0, m_req});
        check("addr", imem_addr, e_addr);
        check("valid", {15'b0, instr_valid}, {15'b0, e_valid});
        check("instr", instr, head[31:16]);
        check("instr_pc", instr_pc, head[15:0]);
        check("pcplus2", pcplus2, e_valid ? head[15:0] + 16'd2 : 16'h0);
        check("op", {13'b0, op}, {13'b0, head[31:29]});
        check("select", {15'b0, select}, {15'b0, head[28]});
        check("funct", {12'b0, funct}, {12'b0, head[19:16]});
`ifdef MIPS16_FETCH_STATS_EN
        check("flush_count", flush_count, m_flush);
`endif
    endtask

    task automatic model_step();
        bit          redir;
        bit          popv;
        logic [15:0] tgt;
        redir = jump | pcsrc;
        tgt   = jump ? pcjump : pcbranch;
        popv  = (mq.size() != 0) && instr_ready;
        if (redir) begin
            if (m_flush != 16'hFFFF)
                m_flush = m_flush + 16'd1;
            mq.delete();
            if (m_req && !m_drop && !imem_ack) begin
                m_drop  = 1'b1;
                m_stale = m_pc;
            end else if (m_drop && imem_ack) begin
                m_drop = 1'b0;
            end
            m_req = 1'b1;
            m_pc  = tgt;
        end else if (m_drop) begin
            if (popv)
                void'(mq.pop_front());
            if (imem_ack)
                m_drop = 1'b0;
        end else if (m_req) begin
            if (popv)
                void'(mq.pop_front());
            if (imem_ack) begin
                mq.push_back({imem_rdata, m_pc});
                m_pc  = m_pc + 16'd2;
                m_req = (mq.size() < DEPTH);
            end
        end else begin
            if (popv)
                void'(mq.pop_front());
            m_req = (mq.size() < DEPTH);
        end
    endtask

    task automatic drive(input bit rdy, input bit ack, input bit ps,
                         input bit jp, input logic [15:0] pb,
                         input logic [15:0] pj);
        instr_ready = rdy;
        imem_ack    = ack;
        pcsrc       = ps;
        jump        = jp;
        pcbranch    = pb;
        pcjump      = pj;
        imem_rdata  = ack ? mem_word(m_drop ? m_stale : m_pc) : 16'hDEAD;
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic step(input bit rdy, input bit ack, input bit ps,
                        input bit jp, input logic [15:0] pb,
                        input logic [15:0] pj);
        @(posedge clk);
        #1;
        drive(rdy, ack, ps, jp, pb, pj);
    endtask

    task automatic mid_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_req", {15'b0, imem_req}, 16'h0);
        check("rst_valid", {15'b0, instr_valid}, 16'h0);
        check("rst_addr", imem_addr, 16'h0000);
`ifdef MIPS16_FETCH_STATS_EN
        check("rst_flush", flush_count, 16'h0);
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    logic [15:0] wa [2];
    int          wn;
    logic [15:0] saved;

    initial begin
        clk         = 1'b0;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0;
        pcsrc       = 1'b0;
        jump        = 1'b0;
        pcbranch    = 16'h0;
        pcjump      = 16'h0;
        instr_ready = 1'b0;
        wa[0]       = 16'h1234;
        wa[1]       = 16'h1234;
        wn          = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        check("wrap_rst_addr", w_addr, 16'hFFFE);

        // Release with ack high while idle: the ack must be ignored
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            if (w_req && wn < 2) begin
                wa[wn] = w_addr;
                wn++;
            end
        end
        check("wrap0", wa[0], 16'hFFFE);
        check("wrap1", wa[1], 16'h0000);

        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 16'h0100);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        check("redir_valid", {15'b0, instr_valid}, 16'h0);
        check("redir_addr", imem_addr, 16'h0100);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        saved = m_pc;
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("drop_addr", imem_addr, saved);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        check("drop_hold", imem_addr, saved);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        check("drop_tgt", imem_addr, 16'h0040);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

        mid_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        check("restart_addr", imem_addr, 16'h0000);
        check("restart_req", {15'b0, imem_req}, 16'h1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
                 16'($urandom), 16'($urandom));
            if (i == 1500)
                mid_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips16_fetch.md
# mips16_fetch

Instruction fetch stage for the 16-bit MIPS core, directly upstream of the controller/decoder.
- Holds the PC and issues one-outstanding requests to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents the head instruction with pre-split `op`/`funct`/`select` fields.
- Redirects on the controller's `pcsrc`/`jump` outcome, flushing the FIFO and discarding any in-flight fetch.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC loaded on reset.
- `DEPTH`, 2, instruction FIFO entries (≥2).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  16  byte address of fetch; stable while `imem_req` is high.
- `imem_ack`  in  1  memory returns data this cycle; may be asserted in the same cycle as `imem_req`.
- `imem_rdata`  in  16  instruction word, valid when `imem_ack` is high.
- `pcsrc`  in  1  taken branch (from controller).
- `jump`  in  1  jump (from controller).
- `pcbranch`  in  16  branch target.
- `pcjump`  in  16  jump target.
- `instr_ready`  in  1  downstream accepts the head instruction.
- `instr_valid`  out  1  head instruction valid.
- `instr`  out  16  head instruction word.
- `instr_pc`  out  16  address of head instruction.
- `pcplus2`  out  16  `instr_pc + 2`.
- `op`  out  3  `instr[15:13]`.
- `select`  out  1  `instr[12]`.
- `funct`  out  4  `instr[3:0]`.

## Operation
- `redirect = jump | pcsrc`; target = `pcjump` if `jump`, else `pcbranch` (jump has priority).
- FIFO entries: {instr, pc}. Pop when `instr_valid & instr_ready`. `count` ranges 0..DEPTH.
- FSM states:
  - IDLE: `imem_req` = 0. Go to REQ when next `count` < DEPTH.
  - REQ: `imem_req` = 1, `imem_addr` = pc.
    - On `imem_ack` without redirect: push {rdata, pc} and set pc += 2. Stay in REQ if post-push `count` < DEPTH, else go to IDLE.
  - DROP: `imem_req` = 1 and `imem_addr` holds the stale address. On `imem_ack`, discard the data and go to REQ.
- Redirect rules (any state, highest priority):
  - FIFO is flushed (`count` ← 0); a same-cycle pop is irrelevant.
  - pc ← target.
  - REQ without ack → DROP. REQ with ack → data discarded, stay in REQ. IDLE → REQ.
  - DROP without ack → stay in DROP with pc updated to the new target. DROP with ack → REQ.
- Flow control: at most one fetch outstanding. A push never occurs when `count` == DEPTH. Simultaneous push and pop leaves `count` unchanged.
- Arithmetic: pc is 16 bits, +2 wraps 16'hFFFE → 16'h0000. Bit 0 of targets is passed through unmodified.
- When `instr_valid` = 0: `instr`, `op`, `select`, `funct`, `instr_pc`, and `pcplus2` drive 0.

## Timing
- Reset values: state IDLE, pc = RESET_PC, `count` = 0, `imem_req` = 0, `imem_addr` = RESET_PC, `instr_valid` = 0, all instruction outputs 0.
- After reset release: first edge IDLE → REQ; `imem_req` rises in the following cycle.
- Fetch latency: an instruction acked in cycle N appears with `instr_valid` = 1 in cycle N+1.
- Sustained rate: one instruction per cycle when `imem_ack` is combinational and downstream always ready.
- Redirect in cycle N: `instr_valid` = 0 in N+1. First target instruction is valid no earlier than N+2 (REQ/IDLE case); in the DROP case, one cycle after the target fetch is acked.
- Reset asserted mid-fetch: state is cleared immediately. A late `imem_ack` arriving after reset while in IDLE is ignored.
- `op`/`funct`/`select` are combinational from the FIFO head; no extra latency.

## Configuration
- `MIPS16_FETCH_STATS_EN` defined: adds output `flush_count` [15:0].
  - Increments on every cycle with `redirect` = 1, saturating at 16'hFFFF.
  - Reset to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset release, `imem_ack` tied high, `instr_ready` = 1, memory returns addr-derived words:
  - `imem_addr` sequence 0000, 0002, 0004…
  - `instr_valid` from cycle 3 after release, one per cycle.
  - `instr_pc` matching `imem_addr`; `pcplus2` = `instr_pc` + 2.
- `instr_ready` = 0 for 6 cycles:
  - FIFO fills to DEPTH = 2 and `imem_req` drops.
  - On release, `instr_pc` sequence continues 0000, 0002, 0004 with no gap or duplicate.
- Redirect while idle: `jump` = 1, `pcjump` = 0x0100, `pcsrc` = 1, `pcbranch` = 0x0200 in the same cycle:
  - `instr_valid` = 0 next cycle.
  - Next fetch address is 0x0100; buffered old entries never appear.
- `imem_ack` delayed 3 cycles and `pcsrc` = 1 (`pcbranch` = 0x0040) during the wait:
  - `imem_addr` stays at the stale address until ack.
  - Stale data is discarded; next request is to 0x0040.
- pc wrap: RESET_PC = 0xFFFE → fetch addresses FFFE then 0000.
- Reset asserted mid-REQ:
  - `imem_req`, `instr_valid`, and `count` clear asynchronously.
  - Fetch restarts at RESET_PC.
  - With `MIPS16_FETCH_STATS_EN`, `flush_count` returns to 0.
